// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 feeder types plus block-count and padding helpers.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, RD, LOAD, EMIT, DONE} state_t;

    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    function automatic logic [12:0] num_blocks(input logic [15:0] len);
        logic [16:0] s;
        s = {1'b0, len} + 17'd18;
        return s[16:4];
    endfunction

    // Pad word for stream index n at or beyond the message end; the upper length word is always 0
    function automatic logic [31:0] pad_word(input logic [16:0] n, input logic [15:0] len, input logic [16:0] tot);
        return (n == {1'b0, len}) ? PAD_MARKER : (n == tot - 17'd1) ? {11'd0, len, 5'd0} : 32'd0;
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: reads an N-word message and streams SHA-256 padded 16-word blocks.
// Define SHA256_PAD_LEN_PORT_EN to add the runtime msg_words length port.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
`ifdef SHA256_PAD_LEN_PORT_EN
    input  logic [15:0] msg_words,
`endif
    output logic [15:0] mem_addr,
    output logic        mem_we,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        out_final,
    output logic        busy,
    output logic        done
);

    state_t      state, state_n;
    logic [15:0] base, base_n, addr_n;
    logic [16:0] n, n_n, nx;
    logic [31:0] data_n;
    logic        valid_n;

`ifdef SHA256_PAD_LEN_PORT_EN
    logic [15:0] len, len_n, len_in;
    logic [16:0] tot, tot_n;
    assign len_in = (msg_words > 16'(NUM_OF_WORDS)) ? 16'(NUM_OF_WORDS) : msg_words;
`else
    localparam logic [15:0] len    = 16'(NUM_OF_WORDS);
    localparam logic [15:0] len_in = len;
    localparam logic [16:0] tot    = {num_blocks(len), 4'd0};
`endif

    always_comb begin
        state_n = state;
        base_n  = base;
        n_n     = n;
        addr_n  = mem_addr;
        data_n  = out_data;
        valid_n = out_valid;
`ifdef SHA256_PAD_LEN_PORT_EN
        len_n   = len;
        tot_n   = tot;
`endif
        nx      = n + 17'd1;
        case (state)
            IDLE: if (start) begin
                base_n = message_addr;
                n_n    = '0;
`ifdef SHA256_PAD_LEN_PORT_EN
                len_n  = len_in;
                tot_n  = {num_blocks(len_in), 4'd0};
`endif
                if (len_in != 16'd0) begin
                    state_n = RD;
                    addr_n  = message_addr;
                end else begin
                    state_n = EMIT;
                    data_n  = PAD_MARKER;
                    valid_n = 1'b1;
                end
            end
            RD:   state_n = LOAD;
            LOAD: begin
                data_n  = mem_read_data;
                valid_n = 1'b1;
                state_n = EMIT;
            end
            // Pad words are produced back-to-back so only message words pay the memory round trip
            EMIT: if (out_ready) begin
                n_n = nx;
                if (nx < {1'b0, len}) begin
                    valid_n = 1'b0;
                    addr_n  = base + nx[15:0];
                    state_n = RD;
                end else if (nx < tot) begin
                    data_n = pad_word(nx, len, tot);
                end else begin
                    valid_n = 1'b0;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base      <= '0;
            n         <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef SHA256_PAD_LEN_PORT_EN
            len       <= '0;
            tot       <= '0;
`endif
        end else begin
            state     <= state_n;
            base      <= base_n;
            n         <= n_n;
            mem_addr  <= addr_n;
            out_data  <= data_n;
            out_valid <= valid_n;
`ifdef SHA256_PAD_LEN_PORT_EN
            len       <= len_n;
            tot       <= tot_n;
`endif
        end
    end

    assign mem_we    = 1'b0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign out_first = out_valid && (n[3:0] == 4'd0);
    assign out_last  = out_valid && (n[3:0] == 4'd15);
    assign out_final = out_valid && (n == tot - 17'd1);

endmodule
